// File: rtl/idli_sqi_fetch_buf_m_if.sv
// Read-data path between the SQI controller/core (master) and the fetch buffer (slave).
// Handshake: a head entry transfers at a posedge where fetch_vld and fetch_rdy are both high.
interface idli_sqi_fetch_buf_m_if;
  logic [1:0]  sqi_ctr;
  logic        sqi_ctr_last_cycle;
  logic        sqi_data_phase;
  logic [3:0]  sqi_rd_data;
  logic        sqi_redirect;
  logic [15:0] redirect_pc;
  logic [15:0] fetch_instr;
  logic [15:0] fetch_pc;
  logic        fetch_vld;
  logic        fetch_rdy;
  logic        fetch_full;
  logic        fetch_ovf;

  modport master (
    output sqi_ctr, sqi_ctr_last_cycle, sqi_data_phase, sqi_rd_data,
    output sqi_redirect, redirect_pc, fetch_rdy,
    input  fetch_instr, fetch_pc, fetch_vld, fetch_full, fetch_ovf
  );

  modport slave (
    input  sqi_ctr, sqi_ctr_last_cycle, sqi_data_phase, sqi_rd_data,
    input  sqi_redirect, redirect_pc, fetch_rdy,
    output fetch_instr, fetch_pc, fetch_vld, fetch_full, fetch_ovf
  );
endinterface

// File: rtl/idli_sqi_fetch_buf_m.sv
// Assembles SQI read nibbles into 16-bit instruction words tagged with their PC
// and queues them in a small FIFO for the decode stage.
module idli_sqi_fetch_buf_m #(
  parameter int DEPTH = 2
) (
  input  logic                  i_sqi_gck,
  input  logic                  i_sqi_rst_n,
  idli_sqi_fetch_buf_m_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [15:0] asm_q;
  logic [15:0] push_pc_q;
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        ovf_q;
  logic [15:0] mem_instr [DEPTH];
  logic [15:0] mem_pc    [DEPTH];

  logic        redirect_take;
  logic        push;
  logic        pop;
  logic        push_ok;
  logic        empty;
  logic        full;
  logic [15:0] word;

  assign redirect_take = bus.sqi_redirect & bus.sqi_ctr_last_cycle;
  assign push          = bus.sqi_data_phase & bus.sqi_ctr_last_cycle & ~redirect_take;
  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop           = ~empty & bus.fetch_rdy & ~redirect_take;
  // A same-cycle pop frees the slot this push needs, so a full FIFO still accepts it.
  assign push_ok       = push & (~full | pop);
  assign word          = {asm_q[15:4], bus.sqi_rd_data};

  assign bus.fetch_vld   = ~empty;
  assign bus.fetch_full  = full;
  assign bus.fetch_ovf   = ovf_q;
  assign bus.fetch_instr = empty ? 16'h0000 : mem_instr[rd_ptr_q[AW-1:0]];
  assign bus.fetch_pc    = empty ? 16'h0000 : mem_pc[rd_ptr_q[AW-1:0]];

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      asm_q     <= 16'h0000;
      push_pc_q <= 16'h0000;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
    end else if (redirect_take) begin
      asm_q     <= 16'h0000;
      push_pc_q <= bus.redirect_pc;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (bus.sqi_data_phase) begin
        case (bus.sqi_ctr)
          2'd0:    asm_q[15:12] <= bus.sqi_rd_data;
          2'd1:    asm_q[11:8]  <= bus.sqi_rd_data;
          2'd2:    asm_q[7:4]   <= bus.sqi_rd_data;
          default: asm_q[3:0]   <= bus.sqi_rd_data;
        endcase
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      // Dropped words still consume a PC so later tags stay aligned with memory.
      if (push)    push_pc_q <= push_pc_q + 16'd1;
      if (push & ~push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge i_sqi_gck) begin
    if (push_ok) begin
      mem_instr[wr_ptr_q[AW-1:0]] <= word;
      mem_pc[wr_ptr_q[AW-1:0]]    <= push_pc_q;
    end
  end

endmodule

// File: tb/tb_idli_sqi_fetch_buf_m.sv
// Self-checking bench for idli_sqi_fetch_buf_m: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_idli_sqi_fetch_buf_m;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  idli_sqi_fetch_buf_m_if bus ();

  idli_sqi_fetch_buf_m #(.DEPTH(DEPTH)) dut (
    .i_sqi_gck   (clk),
    .i_sqi_rst_n (rst_n),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc_q[$];
  logic [3:0]  m_nib [4];
  logic [15:0] m_pc;
  logic        m_ovf;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc_q.delete();
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_pc  = 16'h0000;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] ctr, input logic dp, input logic [3:0] d,
                            input logic redir, input logic [15:0] rpc, input logic rdy);
    int size_before;
    logic do_pop;
    if (redir && ctr == 2'd3) begin
      model_reset_keep_ovf(rpc);
    end else begin
      size_before = exp_q.size();
      do_pop = (size_before > 0) && rdy;
      if (do_pop) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (dp && ctr == 2'd3) begin
        if (size_before < DEPTH || do_pop) begin
          exp_q.push_back({m_nib[0], m_nib[1], m_nib[2], d});
          exp_pc_q.push_back(m_pc);
        end else begin
          m_ovf = 1'b1;
        end
        m_pc = m_pc + 16'd1;
      end
      if (dp) m_nib[ctr] = d;
    end
  endtask

  task automatic model_reset_keep_ovf(input logic [15:0] rpc);
    exp_q.delete();
    exp_pc_q.delete();
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_pc = rpc;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vld"},   {15'h0, bus.fetch_vld},  {15'h0, exp_q.size() > 0});
    check({tag, ".full"},  {15'h0, bus.fetch_full}, {15'h0, exp_q.size() == DEPTH});
    check({tag, ".ovf"},   {15'h0, bus.fetch_ovf},  {15'h0, m_ovf});
    check({tag, ".instr"}, bus.fetch_instr, (exp_q.size() > 0) ? exp_q[0] : 16'h0000);
    check({tag, ".pc"},    bus.fetch_pc,    (exp_pc_q.size() > 0) ? exp_pc_q[0] : 16'h0000);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check 1 ns later.
  task automatic cycle(input logic [1:0] ctr, input logic dp, input logic [3:0] d,
                       input logic redir, input logic [15:0] rpc, input logic rdy);
    bus.sqi_ctr            = ctr;
    bus.sqi_ctr_last_cycle = (ctr == 2'd3);
    bus.sqi_data_phase     = dp;
    bus.sqi_rd_data        = d;
    bus.sqi_redirect       = redir;
    bus.redirect_pc        = rpc;
    bus.fetch_rdy          = rdy;
    @(posedge clk);
    model_step(ctr, dp, d, redir, rpc, rdy);
    #1;
    check_all("cyc");
  endtask

  task automatic send_word(input logic [15:0] w, input logic rdy_last);
    logic [15:0] tmp;
    tmp = w;
    cycle(2'd0, 1'b1, tmp[15:12], 1'b0, 16'h0, 1'b0);
    cycle(2'd1, 1'b1, tmp[11:8],  1'b0, 16'h0, 1'b0);
    cycle(2'd2, 1'b1, tmp[7:4],   1'b0, 16'h0, 1'b0);
    cycle(2'd3, 1'b1, tmp[3:0],   1'b0, 16'h0, rdy_last);
  endtask

  task automatic do_redirect(input logic [15:0] rpc);
    cycle(2'd3, 1'b0, 4'h0, 1'b1, rpc, 1'b0);
  endtask

  task automatic idle_pop();
    cycle(2'd0, 1'b0, 4'h0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic apply_reset();
    bus.sqi_data_phase = 1'b0;
    bus.sqi_redirect   = 1'b0;
    bus.fetch_rdy      = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.sqi_ctr = 2'd0; bus.sqi_ctr_last_cycle = 1'b0; bus.sqi_data_phase = 1'b0;
    bus.sqi_rd_data = 4'h0; bus.sqi_redirect = 1'b0; bus.redirect_pc = 16'h0;
    bus.fetch_rdy = 1'b0;
    rst_n = 1'b1;
    #3;
    apply_reset();

    // Fill to full, then overflow
    do_redirect(16'h0100);
    send_word(16'h1234, 1'b0);
    send_word(16'hABCD, 1'b0);
    check("fill.head", bus.fetch_instr, 16'h1234);
    check("fill.pc", bus.fetch_pc, 16'h0100);
    check("fill.full", {15'h0, bus.fetch_full}, 16'h0001);
    send_word(16'h5555, 1'b0);
    check("ovf.set", {15'h0, bus.fetch_ovf}, 16'h0001);
    idle_pop();
    check("pop1.head", bus.fetch_instr, 16'hABCD);
    check("pop1.pc", bus.fetch_pc, 16'h0101);
    idle_pop();
    check("pop2.vld", {15'h0, bus.fetch_vld}, 16'h0000);
    send_word(16'h0F0F, 1'b0);
    check("after_drop.pc", bus.fetch_pc, 16'h0103);

    // Simultaneous push and pop while full
    apply_reset();
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b1);
    check("pushpop.full", {15'h0, bus.fetch_full}, 16'h0001);
    check("pushpop.ovf", {15'h0, bus.fetch_ovf}, 16'h0000);
    check("pushpop.head", bus.fetch_instr, 16'h2222);

    // Mid-word redirect with FIFO full
    cycle(2'd0, 1'b1, 4'h9, 1'b0, 16'h0, 1'b0);
    cycle(2'd1, 1'b1, 4'h8, 1'b0, 16'h0, 1'b0);
    cycle(2'd2, 1'b1, 4'h7, 1'b0, 16'h0, 1'b0);
    cycle(2'd3, 1'b1, 4'h6, 1'b1, 16'h2000, 1'b0);
    check("redir.vld", {15'h0, bus.fetch_vld}, 16'h0000);
    cycle(2'd0, 1'b1, 4'hC, 1'b0, 16'h0, 1'b0);
    cycle(2'd1, 1'b1, 4'h0, 1'b1, 16'h7777, 1'b0);
    cycle(2'd2, 1'b1, 4'hD, 1'b0, 16'h0, 1'b0);
    cycle(2'd3, 1'b1, 4'hE, 1'b0, 16'h0, 1'b0);
    check("redir.word", bus.fetch_instr, 16'hC0DE);
    check("redir.pc", bus.fetch_pc, 16'h2000);

    // PC wrap
    do_redirect(16'hFFFF);
    send_word(16'h4321, 1'b0);
    send_word(16'h8765, 1'b0);
    check("wrap.pc0", bus.fetch_pc, 16'hFFFF);
    idle_pop();
    check("wrap.pc1", bus.fetch_pc, 16'h0000);
    check("wrap.instr1", bus.fetch_instr, 16'h8765);

    // Reset mid-word
    idle_pop();
    cycle(2'd0, 1'b1, 4'hF, 1'b0, 16'h0, 1'b0);
    cycle(2'd1, 1'b1, 4'hF, 1'b0, 16'h0, 1'b0);
    apply_reset();
    send_word(16'h0A50, 1'b0);
    check("postrst.word", bus.fetch_instr, 16'h0A50);
    check("postrst.pc", bus.fetch_pc, 16'h0000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] c;
      c = 2'(i % 4);
      cycle(c, ($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 19) == 0), 16'($urandom_range(0, 65535)),
            ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idli_sqi_fetch_buf_m.md
Name: idli_sqi_fetch_buf_m

Overview:
- Sits directly downstream of the SQI controller on the read-data path.
- Collects the four read nibbles of each 16-bit word from memory into a full instruction word and tags it with its word address (PC).
- Holds completed words in a small FIFO that the decode stage pops with a valid/ready handshake.
- Flushes the FIFO and reloads the PC when the core redirects fetch.

Parameters:
- DEPTH, 2, number of 16-bit word entries in the FIFO. Power of two, ≥2.

Ports:
- i_sqi_gck  input  1  core/SQI clock; all state updates on posedge.
- i_sqi_rst_n  input  1  reset, asynchronous, active-low.
- i_sqi_ctr  input  2  nibble counter; 0 = first (most significant) nibble of a word.
- i_sqi_ctr_last_cycle  input  1  high when i_sqi_ctr==3; marks word boundary.
- i_sqi_data_phase  input  1  controller is in read data phase; nibble on i_sqi_rd_data is valid.
- i_sqi_rd_data  input  4  read nibble from the memory.
- i_sqi_redirect  input  1  fetch redirect request; takes effect on a word boundary.
- i_redirect_pc  input  16  new word address, sampled with the redirect.
- o_fetch_instr  output  16  FIFO head instruction word.
- o_fetch_pc  output  16  word address of the FIFO head.
- o_fetch_vld  output  1  FIFO non-empty.
- i_fetch_rdy  input  1  consumer pops the head when o_fetch_vld is also high.
- o_fetch_full  output  1  FIFO full; upstream uses it to gate SCK/hold.
- o_fetch_ovf  output  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - FIFO empty; o_fetch_vld=0, o_fetch_full=0, o_fetch_ovf=0.
  - Assembly shift register = 0; next-push PC = 0.
  - o_fetch_instr and o_fetch_pc = 0 while empty.
- Assembly:
  - When i_sqi_data_phase=1, the nibble is written into bits [15-4*ctr -: 4] of the assembly register.
  - When i_sqi_data_phase=0, the assembly register holds its value.
- Push:
  - Condition: i_sqi_data_phase & i_sqi_ctr_last_cycle & ~redirect_take.
  - The complete word is {asm[15:4], i_sqi_rd_data}; the last nibble bypasses the register.
  - The word enters the FIFO at the next posedge with tag = push PC.
  - Push PC then increments by 1, modulo 2^16: 0xFFFF wraps to 0x0000.
- Pop: o_fetch_vld & i_fetch_rdy removes the head at posedge.
- Latency: a word is visible on o_fetch_instr/o_fetch_vld the cycle after its last nibble.
- Simultaneous push and pop:
  - Both take effect and occupancy is unchanged.
  - This includes the full case: a pop while full frees a slot for the same-cycle push, with no overflow.
- Overflow: push while full and no pop:
  - Word is discarded; push PC still increments.
  - o_fetch_ovf set, and stays set until reset.
- Redirect:
  - redirect_take = i_sqi_redirect & i_sqi_ctr_last_cycle.
  - On redirect_take: FIFO emptied, assembly register cleared, push PC loaded with i_redirect_pc.
  - Any same-cycle push or pop is ignored.
  - i_sqi_redirect outside the last cycle has no effect.
- Full/empty tracking:
  - Read/write pointers are log2(DEPTH)+1 bits wide.
  - full = MSBs differ & low bits equal; empty = pointers equal.
- Reset mid-word: asynchronous clear of everything; a partial word is lost.
- No combinational path from i_fetch_rdy to any output.

Test Plan:
- Reset, redirect to 0x0100, then stream nibbles 1,2,3,4 then A,B,C,D with i_fetch_rdy=0 -> head 0x1234 @PC 0x0100, 2nd entry 0xABCD @0x0101, o_fetch_full=1, o_fetch_ovf=0.
- Continue a third word 0x5555 with rdy=0 -> word dropped, o_fetch_ovf=1; pop twice -> 0x1234 then 0xABCD; the next pushed word is tagged PC 0x0103.
- FIFO full with a push on the same cycle as rdy=1 -> pop of the head and push both succeed, occupancy stays 2, o_fetch_ovf stays 0.
- FIFO holding 2 words, mid-word redirect to 0x2000 on ctr==3 -> o_fetch_vld=0 next cycle; next word tagged 0x2000 containing only new nibbles. Redirect asserted only at ctr==1 -> no effect.
- Redirect to 0xFFFF, push 2 words -> tags 0xFFFF then 0x0000.
- Assert i_sqi_rst_n low after ctr==1 of a word, release -> all outputs at reset values; the following 4-nibble word assembles cleanly with no stale nibbles.
